sample_frame_aggregator: RTL and testbench
==========================================

// Module: sample_frame_aggregator
// PURPOSE
//  Upstream feeder of the multi-channel decimating biquad lowpass. Collects a TDM stream of
//  per-channel samples into one CHANNEL_COUNT*DATA_WIDTH frame and toggles outputToggle per frame.
//  Raises decimateFlag on every Nth frame so the lowpass emits at the decimated rate.
//  Detects and counts channel-sequence errors.
// PARAMETERS
//  DATA_WIDTH        28    bits per channel sample
//  CHANNEL_COUNT     4     channels per frame, >=1
//  DECIMATION_FACTOR 1000  frames per flagged frame; reset value of the runtime factor
//  ERR_COUNT_WIDTH   16    width of saturating sequence-error counter
// PORTS
//  clk            in   1                        system clock, all logic on posedge
//  rst_n          in   1                        asynchronous, active-low reset
//  sampleValid    in   1                        sampleChannel/sampleData valid this cycle
//  sampleChannel  in   CHAN_IDX_W               channel index of sample, 0..CHANNEL_COUNT-1
//  sampleData     in   DATA_WIDTH               sample value, passed through unmodified
//  csrStrobe      in   1                        CSR transaction frame (DECIM_CSR_EN only)
//  GPIO_OUT       in   32                       CSR address/data word (DECIM_CSR_EN only)
//  outputData     out  CHANNEL_COUNT*DATA_WIDTH frame; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//  outputToggle   out  1                        inverts once per completed frame
//  decimateFlag   out  1                        level, qualified by outputToggle change
//  sequenceError  out  1                        one-cycle pulse per out-of-order sample
//  errorCount     out  ERR_COUNT_WIDTH          saturating count of sequenceError pulses
// BEHAVIOUR
//  - Reset: every output 0; nextChan=0; frameCount=0; factor=DECIMATION_FACTOR; shadow lanes 0.
//  - Accept: sampleValid && sampleChannel==nextChan -> write shadow lane nextChan.
//    nextChan increments, wraps to 0 after CHANNEL_COUNT-1.
//  - Frame complete: accepted sample is channel CHANNEL_COUNT-1.
//    Next edge: outputData <= shadow with final lane merged, outputToggle inverts, decimateFlag updates.
//    Latency from last-sample edge to toggle: 1 clk. outputData/decimateFlag stable until next frame.
//  - decimateFlag = (frameCount==factor-1); frameCount then wraps to 0, else increments.
//    factor 0 treated as 1; factor 1 flags every frame.
//  - Mismatch (sampleValid && sampleChannel!=nextChan): sequenceError pulses next cycle.
//    errorCount +1, sticks at all-ones. Partial frame discarded, no toggle.
//    Offending sample is channel 0 -> stored as new frame start, nextChan=1; else nextChan=0.
//  - sampleChannel >= CHANNEL_COUNT is always a mismatch.
//  - Back-to-back valid every cycle supported; no backpressure, consumer must keep up.
//  - rst_n asserted mid-frame: partial frame lost; outputs return to reset values asynchronously.
// CONFIGURATION
//  DECIM_CSR_EN defined:
//    - Factor is runtime-writable via CSR: csrStrobe high for two consecutive cycles.
//    - Cycle 1: GPIO_OUT = address. Cycle 2: GPIO_OUT[31]=1 write, [30:0] data.
//    - Address DECIM_FACTOR_ADDR writes factor=data[23:0]; errorCount is cleared on the same write.
//    - Write also clears frameCount. New factor applies from the next completed frame.
//    - Write coinciding with frame completion: completing frame uses old factor, frameCount then 0.
//    - Strobe dropped after cycle 1, or [31]=0: no effect.
//  DECIM_CSR_EN undefined:
//    - csrStrobe/GPIO_OUT ignored (ports kept for pin compatibility).
//    - factor is constant DECIMATION_FACTOR.
// STRUCTURE
//  - Package decim_pkg: CHAN_IDX_W = max(1,$clog2(CHANNEL_COUNT)), DECIM_FACTOR_ADDR=32'h40,
//    FACTOR_WIDTH=24, CSR write-bit index 31.
//  - Sub-module csr_word_capture: two-cycle strobe decoder producing wrStrobe/wrAddr/wrData.
//    Instantiated only under DECIM_CSR_EN.
// TESTING (CHANNEL_COUNT=4, DATA_WIDTH=28, factor=3)
//  - Reset: hold rst_n=0 -> all outputs 0, outputToggle 0.
//    Release, no valid for 50 clk -> no toggle.
//  - In-order ch0..3 = 10,20,30,40 -> one toggle 1 clk after ch3.
//    outputData lanes 10,20,30,40; decimateFlag 0.
//  - 6 consecutive frames -> decimateFlag 1 on frames 3 and 6 only; 6 toggles.
//  - Sequence ch0,ch1,ch3 -> sequenceError pulse, errorCount 1, no toggle.
//    Then ch0..3 -> normal frame.
//  - Sequence ch0,ch1,ch0,ch1,ch2,ch3 -> one error; frame from second ch0 emitted.
//  - DECIM_CSR_EN: write factor=1 mid-stream -> every subsequent frame flagged, errorCount 0.
//    Without macro, same CSR traffic -> flags stay every 3rd frame.

Source files
------------

// File: rtl/sample_frame_aggregator_pkg.sv
// Shared constants for the sample frame aggregator and its CSR capture logic.
// The runtime decimation factor (and csr_word_capture) exists only when
// DECIM_CSR_EN is defined.
package decim_pkg;

    localparam int          FACTOR_WIDTH      = 24;
    localparam logic [31:0] DECIM_FACTOR_ADDR = 32'h40;
    localparam int          CSR_WR_BIT        = 31;

    // Channel index width, never narrower than one bit.
    function automatic int chan_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_frame_aggregator_csr_word_capture.sv
// Two-cycle CSR strobe decoder. The first strobed cycle carries the address;
// the second carries the write bit and the data. If the strobe drops after the
// first cycle, the captured address is discarded.
module csr_word_capture
    import decim_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_csr_strobe,
    input  logic [31:0] i_gpio_out,
    output logic        o_wr_strobe,
    output logic [31:0] o_wr_addr,
    output logic [30:0] o_wr_data
);

    logic        r_armed;
    logic [31:0] r_addr;

    // Track the address phase and latch the address word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_armed <= i_csr_strobe && !r_armed;
            if (i_csr_strobe && !r_armed)
                r_addr <= i_gpio_out;
        end
    end

    assign o_wr_strobe = r_armed && i_csr_strobe && i_gpio_out[CSR_WR_BIT];
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = i_gpio_out[CSR_WR_BIT-1:0];

endmodule

// File: rtl/sample_frame_aggregator.sv
// Collects a TDM stream of per-channel samples into one wide frame. The block
// toggles outputToggle once per completed frame, flags every Nth frame for the
// decimating lowpass, and counts channel-sequence errors.
// Optional feature macro: DECIM_CSR_EN (runtime-writable decimation factor).
module sample_frame_aggregator
    import decim_pkg::*;
#(
    parameter int DATA_WIDTH        = 28,
    parameter int CHANNEL_COUNT     = 4,
    parameter int DECIMATION_FACTOR = 1000,
    parameter int ERR_COUNT_WIDTH   = 16,
    parameter int CHAN_IDX_W        = chan_idx_w(CHANNEL_COUNT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                sampleValid,
    input  logic [CHAN_IDX_W-1:0]               sampleChannel,
    input  logic [DATA_WIDTH-1:0]               sampleData,
    input  logic                                csrStrobe,
    input  logic [31:0]                         GPIO_OUT,
    output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] outputData,
    output logic                                outputToggle,
    output logic                                decimateFlag,
    output logic                                sequenceError,
    output logic [ERR_COUNT_WIDTH-1:0]          errorCount
);

    localparam logic [CHAN_IDX_W-1:0]   LAST_CHAN    = CHAN_IDX_W'(CHANNEL_COUNT - 1);
    localparam logic [FACTOR_WIDTH-1:0] RESET_FACTOR = FACTOR_WIDTH'(DECIMATION_FACTOR);

    logic [CHAN_IDX_W-1:0]                r_next_chan;
    logic [DATA_WIDTH-1:0]                r_shadow [CHANNEL_COUNT];
    logic [FACTOR_WIDTH-1:0]              r_frame_count;
    logic [CHANNEL_COUNT*DATA_WIDTH-1:0]  r_out;
    logic                                 r_toggle;
    logic                                 r_flag;
    logic                                 r_seq_err;
    logic [ERR_COUNT_WIDTH-1:0]           r_err_count;

    logic [FACTOR_WIDTH-1:0]              w_factor;
    logic [FACTOR_WIDTH-1:0]              w_factor_eff;
    logic                                 w_csr_wr;
    logic                                 w_accept;
    logic                                 w_mismatch;
    logic                                 w_complete;
    logic                                 w_flag_hit;
    logic [CHANNEL_COUNT*DATA_WIDTH-1:0]  w_frame;

`ifdef DECIM_CSR_EN
    logic                    w_wr_strobe;
    logic [31:0]             w_wr_addr;
    logic [30:0]             w_wr_data;
    logic [FACTOR_WIDTH-1:0] r_factor;
    logic                    w_unused_data;

    csr_word_capture u_csr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_csr_strobe (csrStrobe),
        .i_gpio_out   (GPIO_OUT),
        .o_wr_strobe  (w_wr_strobe),
        .o_wr_addr    (w_wr_addr),
        .o_wr_data    (w_wr_data)
    );

    assign w_csr_wr      = w_wr_strobe && (w_wr_addr == DECIM_FACTOR_ADDR);
    assign w_unused_data = ^w_wr_data[30:FACTOR_WIDTH];

    // Runtime decimation factor, loaded by a CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_factor <= RESET_FACTOR;
        else if (w_csr_wr)
            r_factor <= w_wr_data[FACTOR_WIDTH-1:0];
    end

    assign w_factor = r_factor;
`else
    logic w_unused_csr;

    assign w_unused_csr = csrStrobe ^ (^GPIO_OUT);
    assign w_csr_wr     = 1'b0;
    assign w_factor     = RESET_FACTOR;
`endif

    // A factor of zero behaves like one: every frame is flagged.
    assign w_factor_eff = (w_factor == '0) ? FACTOR_WIDTH'(1) : w_factor;
    assign w_accept     = sampleValid && (sampleChannel == r_next_chan);
    assign w_mismatch   = sampleValid && !w_accept;
    assign w_complete   = w_accept && (r_next_chan == LAST_CHAN);
    assign w_flag_hit   = (r_frame_count == w_factor_eff - FACTOR_WIDTH'(1));

    // Assemble the outgoing frame; the final lane comes straight from the input.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            if (k == CHANNEL_COUNT - 1)
                w_frame[k*DATA_WIDTH +: DATA_WIDTH] = sampleData;
            else
                w_frame[k*DATA_WIDTH +: DATA_WIDTH] = r_shadow[k];
        end
    end

    // Shadow lanes hold the partial frame; an out-of-order channel 0 restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNEL_COUNT; k++)
                r_shadow[k] <= '0;
        end else if (w_accept) begin
            r_shadow[r_next_chan] <= sampleData;
        end else if (w_mismatch && (sampleChannel == '0)) begin
            r_shadow[0] <= sampleData;
        end
    end

    // Sequence tracking, frame emission, decimation counting and error accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_chan   <= '0;
            r_frame_count <= '0;
            r_out         <= '0;
            r_toggle      <= 1'b0;
            r_flag        <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_seq_err <= w_mismatch;

            if (w_accept)
                r_next_chan <= (r_next_chan == LAST_CHAN) ? '0 : r_next_chan + CHAN_IDX_W'(1);
            else if (w_mismatch)
                r_next_chan <= (sampleChannel == '0 && CHANNEL_COUNT > 1) ? CHAN_IDX_W'(1) : '0;

            if (w_complete) begin
                r_out         <= w_frame;
                r_toggle      <= ~r_toggle;
                r_flag        <= w_flag_hit;
                r_frame_count <= w_flag_hit ? '0 : r_frame_count + FACTOR_WIDTH'(1);
            end

            // A factor write restarts the frame count, even on a completing frame.
            if (w_csr_wr)
                r_frame_count <= '0;

            if (w_csr_wr)
                r_err_count <= '0;
            else if (w_mismatch && (r_err_count != '1))
                r_err_count <= r_err_count + ERR_COUNT_WIDTH'(1);
        end
    end

    assign outputData    = r_out;
    assign outputToggle  = r_toggle;
    assign decimateFlag  = r_flag;
    assign sequenceError = r_seq_err;
    assign errorCount    = r_err_count;

endmodule

// File: tb/tb_sample_frame_aggregator.sv
// Directed bench for sample_frame_aggregator: 4 channels, 28-bit data, factor 3.
// The CSR section expects different results when DECIM_CSR_EN is defined.
module tb_sample_frame_aggregator;

    localparam int DW = 28;
    localparam int CC = 4;
    localparam int EW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sampleValid = 1'b0;
    logic [1:0]      sampleChannel = '0;
    logic [DW-1:0]   sampleData = '0;
    logic            csrStrobe = 1'b0;
    logic [31:0]     GPIO_OUT = '0;
    logic [CC*DW-1:0] outputData;
    logic            outputToggle;
    logic            decimateFlag;
    logic            sequenceError;
    logic [EW-1:0]   errorCount;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_tog = 1'b0;

    sample_frame_aggregator #(
        .DATA_WIDTH        (DW),
        .CHANNEL_COUNT     (CC),
        .DECIMATION_FACTOR (3),
        .ERR_COUNT_WIDTH   (EW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sampleValid   (sampleValid),
        .sampleChannel (sampleChannel),
        .sampleData    (sampleData),
        .csrStrobe     (csrStrobe),
        .GPIO_OUT      (GPIO_OUT),
        .outputData    (outputData),
        .outputToggle  (outputToggle),
        .decimateFlag  (decimateFlag),
        .sequenceError (sequenceError),
        .errorCount    (errorCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CC*DW-1:0] lanes(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    // Present one sample for one clock; returns at the following negedge.
    task automatic send(input logic [1:0] ch, input logic [DW-1:0] d);
        sampleValid   = 1'b1;
        sampleChannel = ch;
        sampleData    = d;
        @(negedge clk);
        sampleValid   = 1'b0;
    endtask

    // Full in-order frame with lane k = base + k, then check the emitted frame.
    task automatic frame_and_check(input string tag, input logic [DW-1:0] base, input logic exp_flag);
        for (int c = 0; c < CC; c++)
            send(2'(c), base + DW'(c));
        exp_tog = ~exp_tog;
        check({tag, "_toggle"}, outputToggle, exp_tog);
        check({tag, "_flag"}, decimateFlag, exp_flag);
        check({tag, "_data"}, outputData, lanes(base, base + 1, base + 2, base + 3));
    endtask

    task automatic csr_write(input logic [31:0] addr, input logic [31:0] word);
        csrStrobe = 1'b1;
        GPIO_OUT  = addr;
        @(negedge clk);
        GPIO_OUT  = word;
        @(negedge clk);
        csrStrobe = 1'b0;
        GPIO_OUT  = '0;
    endtask

    initial begin
        int changes;
        logic exp_flags [6];
        logic csr_flags [3];
        logic [EW-1:0] csr_err;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", outputData, '0);
        check("rst_toggle", outputToggle, 1'b0);
        check("rst_flag", decimateFlag, 1'b0);
        check("rst_seqerr", sequenceError, 1'b0);
        check("rst_errcnt", errorCount, '0);
        rst_n = 1'b1;

        // Idle: no toggles without valid samples
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (outputToggle !== 1'b0) changes++;
        end
        check("idle_toggle", changes, 0);

        // First frame 10,20,30,40 (overall frame 1)
        send(2'd0, 28'd10);
        send(2'd1, 28'd20);
        send(2'd2, 28'd30);
        check("pre_last_toggle", outputToggle, 1'b0);
        send(2'd3, 28'd40);
        exp_tog = 1'b1;
        check("f1_toggle", outputToggle, 1'b1);
        check("f1_data", outputData, lanes(28'd10, 28'd20, 28'd30, 28'd40));
        check("f1_flag", decimateFlag, 1'b0);

        // Six back-to-back frames: overall frames 2..7, flagged on 3 and 6
        exp_flags = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++)
            frame_and_check($sformatf("bb%0d", i), DW'(100 * (i + 1)), exp_flags[i]);

        // Skip from ch1 to ch3: error, no toggle
        send(2'd0, 28'd1);
        send(2'd1, 28'd2);
        send(2'd3, 28'd3);
        check("skip_seqerr", sequenceError, 1'b1);
        check("skip_errcnt", errorCount, 16'd1);
        check("skip_toggle", outputToggle, exp_tog);
        @(negedge clk);
        check("skip_pulse_end", sequenceError, 1'b0);
        frame_and_check("after_skip", 28'd500, 1'b0);

        // Restart on ch0 mid-frame: frame built from the second ch0
        send(2'd0, 28'd7);
        send(2'd1, 28'd8);
        send(2'd0, 28'd900);
        check("restart_seqerr", sequenceError, 1'b1);
        send(2'd1, 28'd901);
        check("restart_pulse_end", sequenceError, 1'b0);
        send(2'd2, 28'd902);
        send(2'd3, 28'd903);
        exp_tog = ~exp_tog;
        check("restart_toggle", outputToggle, exp_tog);
        check("restart_data", outputData, lanes(28'd900, 28'd901, 28'd902, 28'd903));
        check("restart_flag", decimateFlag, 1'b1);
        check("restart_errcnt", errorCount, 16'd2);

        // Outputs hold between frames
        repeat (5) @(negedge clk);
        check("hold_data", outputData, lanes(28'd900, 28'd901, 28'd902, 28'd903));
        check("hold_flag", decimateFlag, 1'b1);
        check("hold_toggle", outputToggle, exp_tog);

        // CSR traffic: dropped strobe and write bit clear must have no effect
        csrStrobe = 1'b1;
        GPIO_OUT  = 32'h40;
        @(negedge clk);
        csrStrobe = 1'b0;
        GPIO_OUT  = 32'h8000_0001;
        @(negedge clk);
        GPIO_OUT  = '0;
        csr_write(32'h40, 32'h0000_0001);
        check("csr_nowrite_errcnt", errorCount, 16'd2);

        // Real write of factor 1
        csr_write(32'h40, 32'h8000_0001);
`ifdef DECIM_CSR_EN
        csr_err   = 16'd0;
        csr_flags = '{1'b1, 1'b1, 1'b1};
`else
        csr_err   = 16'd2;
        csr_flags = '{1'b0, 1'b0, 1'b1};
`endif
        check("csr_errcnt", errorCount, csr_err);
        for (int i = 0; i < 3; i++)
            frame_and_check($sformatf("csr%0d", i), DW'(2000 + 10 * i), csr_flags[i]);

        // Asynchronous reset in the middle of a frame
        send(2'd0, 28'd1);
        send(2'd1, 28'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_toggle", outputToggle, 1'b0);
        check("arst_data", outputData, '0);
        check("arst_flag", decimateFlag, 1'b0);
        check("arst_errcnt", errorCount, '0);
        exp_tog = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frame_and_check("post_arst", 28'd5000, 1'b0);
        check("post_arst_errcnt", errorCount, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
